rej_bounded2_pack: RTL and testbench

- Transmit-side counterpart of the eta=2 rejection sampler, which emits 3-bit mod-5 values (0..4) per coefficient.
- Accepts NUM_COEFF such values per beat and packs them LSB-first into a continuous bit stream.
- Emits OUT_W-bit words (skEncode layout for s1/s2 polynomials) over a valid/ready interface toward the key-memory / API write path.
- Tracks polynomial boundaries and marks the last word of each polynomial.

---
 rtl/rej_bounded2_pack.sv | 125 ++++++++++++
 tb/tb_rej_bounded2_pack.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rej_bounded2_pack.sv
// Packs 3-bit eta=2 coefficients LSB-first into OUT_W-bit words, flagging the last word of each polynomial.
// Optional range check on incoming fields: define REJ_BOUNDED2_PACK_RANGE_CHECK_EN.
//
// state | meaning
// FILL  | accepting beats while the buffer has room for a full beat
// DRAIN | all beats of the polynomial taken; emptying the buffer
module rej_bounded2_pack #(
   parameter int NUM_COEFF      = 4,
   parameter int COEFF_W        = 3,
   parameter int OUT_W          = 32,
   parameter int NUM_POLY_COEFF = 256,
   parameter int BUF_W          = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [NUM_COEFF*COEFF_W-1:0] data_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [OUT_W-1:0]             data_o,
   output logic                         last_o,
   output logic                         error_o
);
   localparam int IN_W   = NUM_COEFF * COEFF_W;
   localparam int BEATS  = NUM_POLY_COEFF / NUM_COEFF;
   localparam int WORDS  = NUM_POLY_COEFF * COEFF_W / OUT_W;
   localparam int FILL_W = $clog2(BUF_W + 1);
   localparam int BEAT_W = $clog2(BEATS);
   localparam int WORD_W = $clog2(WORDS);

   typedef enum logic {ST_FILL, ST_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [BUF_W-1:0]    buffer_q, buffer_d;
   logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
   logic                push, pop;
   logic [BUF_W-1:0]    buffer_base;
   logic [FILL_W-1:0]   ins_offset;

   always_comb begin
      ready_o     = (state_q == ST_FILL) && (fill_cnt_q <= FILL_W'(BUF_W - IN_W));
      valid_o     = (fill_cnt_q >= FILL_W'(OUT_W));
      last_o      = valid_o && (word_cnt_q == WORD_W'(WORDS - 1));
      data_o      = buffer_q[OUT_W-1:0];
      push        = valid_i && ready_o;
      pop         = valid_o && ready_i;

      // Insertion point is relative to the buffer after this cycle's pop shift.
      buffer_base = pop ? (buffer_q >> OUT_W) : buffer_q;
      ins_offset  = pop ? (fill_cnt_q - FILL_W'(OUT_W)) : fill_cnt_q;
      buffer_d    = buffer_base;
      if (push) begin
         buffer_d = buffer_base | (BUF_W'(data_i) << ins_offset);
      end
      fill_cnt_d  = fill_cnt_q - (pop ? FILL_W'(OUT_W) : '0) + (push ? FILL_W'(IN_W) : '0);

      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      word_cnt_d  = word_cnt_q;
      if (push) begin
         if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = ST_DRAIN;
         end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
         end
      end
      if (pop) begin
         if (last_o) begin
            word_cnt_d = '0;
            state_d    = ST_FILL;
         end else begin
            word_cnt_d = word_cnt_q + WORD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FILL;
         buffer_q   <= '0;
         fill_cnt_q <= '0;
         beat_cnt_q <= '0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         buffer_q   <= buffer_d;
         fill_cnt_q <= fill_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         word_cnt_q <= word_cnt_d;
      end
   end

`ifdef REJ_BOUNDED2_PACK_RANGE_CHECK_EN
   localparam logic [COEFF_W-1:0] MAX_VAL = COEFF_W'(4);
   logic error_q, error_d;

   always_comb begin
      error_d = error_q;
      if (push) begin
         for (int k = 0; k < NUM_COEFF; k++) begin
            if (data_i[k*COEFF_W +: COEFF_W] > MAX_VAL) begin
               error_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_rej_bounded2_pack.sv
// Bench for rej_bounded2_pack: bit-level reference packer feeding a word scoreboard, plus vector table and corner sequences.
module tb_rej_bounded2_pack;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [11:0] data_i = '0;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] data_o;
   logic        last_o;
   logic        error_o;

   rej_bounded2_pack dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   bit          q_bits[$];
   logic [31:0] q_words[$];
   logic [31:0] pop_log[$];
   int          word_idx = 0;
   int          n_pop = 0;
   int          n_push = 0;
   int          n_last = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      q_bits.delete();
      q_words.delete();
      pop_log.delete();
      word_idx = 0;
      n_pop    = 0;
      n_push   = 0;
      n_last   = 0;
   endtask

   // Handshakes seen at negedge complete at the following posedge.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_o && ready_i) begin
            n_pop++;
            if (q_words.size() == 0) begin
               check("unexpected_word", data_o, 32'hxxxx_xxxx);
            end else begin
               logic [31:0] exp_w;
               exp_w = q_words.pop_front();
               check("word", data_o, exp_w);
               check("last", {31'd0, last_o}, {31'd0, word_idx == 23});
            end
            word_idx = (word_idx + 1) % 24;
            if (last_o) n_last++;
            pop_log.push_back(data_o);
         end
         if (valid_i && ready_o) begin
            n_push++;
            for (int k = 0; k < 12; k++) q_bits.push_back(data_i[k]);
            while (q_bits.size() >= 32) begin
               logic [31:0] w;
               for (int b = 0; b < 32; b++) w[b] = q_bits.pop_front();
               q_words.push_back(w);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      rst = 1'b0;
   endtask

   task automatic send_beats(input int n, input logic [11:0] d, input bit keep);
      for (int i = 0; i < n; i++) begin
         int b;
         b = 0;
         valid_i = 1'b1;
         data_i  = d;
         while (!ready_o) begin
            @(posedge clk); #1;
            b++;
            if (b > 500) begin
               check("send_timeout", 32'd0, 32'd1);
               valid_i = 1'b0;
               return;
            end
         end
         @(posedge clk); #1;
      end
      valid_i = keep;
   endtask

   task automatic wait_pops(input int target);
      int b;
      b = 0;
      while (n_pop < target) begin
         @(posedge clk); #1;
         b++;
         if (b > 3000) begin
            check("pop_timeout", n_pop, target);
            return;
         end
      end
   endtask

   typedef struct {
      logic [11:0] din;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;
   vec_t vecs[4];

   initial begin
      vecs[0] = '{12'h924, 32'h24924924, 32'h49249249};
      vecs[1] = '{12'h688, 32'h88688688, 32'h86886886};
      vecs[2] = '{12'h000, 32'h00000000, 32'h00000000};
      vecs[3] = '{12'hFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

      do_reset();
      check("rst_valid_o", {31'd0, valid_o}, 32'd0);
      check("rst_last_o",  {31'd0, last_o},  32'd0);
      check("rst_data_o",  data_o,           32'd0);
      check("rst_error_o", {31'd0, error_o}, 32'd0);
      check("rst_ready_o", {31'd0, ready_o}, 32'd1);

      for (int v = 0; v < 4; v++) begin
         do_reset();
         send_beats(64, vecs[v].din, 1'b0);
         wait_pops(24);
         repeat (3) @(posedge clk);
         #1;
         check("vec_pops",  n_pop,  24);
         check("vec_lasts", n_last, 1);
         check("vec_ready_after", {31'd0, ready_o}, 32'd1);
         check("vec_sb_empty", q_words.size() + q_bits.size(), 0);
         if (pop_log.size() >= 2) begin
            check("vec_w0", pop_log[0], vecs[v].w0);
            check("vec_w1", pop_log[1], vecs[v].w1);
         end else begin
            check("vec_logsize", pop_log.size(), 2);
         end
      end
`ifdef REJ_BOUNDED2_PACK_RANGE_CHECK_EN
      check("error_sticky", {31'd0, error_o}, 32'd1);
`else
      check("error_tied", {31'd0, error_o}, 32'd0);
`endif

      // All-4 stream, two back-to-back polynomials.
      do_reset();
      send_beats(64, 12'h924, 1'b0);
      send_beats(64, 12'h924, 1'b0);
      wait_pops(48);
      repeat (3) @(posedge clk);
      #1;
      check("two_poly_pops",  n_pop,  48);
      check("two_poly_lasts", n_last, 2);
      if (pop_log.size() >= 27) begin
         check("poly2_w0", pop_log[24], 32'h24924924);
         check("poly2_w2", pop_log[26], 32'h92492492);
         check("poly1_w23", pop_log[23], 32'h92492492);
      end

      // First-word latency and backpressure.
      do_reset();
      ready_i = 1'b0;
      send_beats(2, 12'h688, 1'b1);
      check("lat_no_valid", {31'd0, valid_o}, 32'd0);
      send_beats(1, 12'h688, 1'b1);
      check("lat_valid", {31'd0, valid_o}, 32'd1);
      repeat (6) @(posedge clk);
      #1;
      check("bp_pushes", n_push, 5);
      check("bp_ready_low", {31'd0, ready_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold_data", data_o, 32'h88688688);
         check("bp_hold_valid", {31'd0, valid_o}, 32'd1);
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      send_beats(59, 12'h688, 1'b0);
      wait_pops(24);
      repeat (3) @(posedge clk);
      #1;
      check("bp_pops", n_pop, 24);
      check("bp_lasts", n_last, 1);

      // DRAIN gating: valid held high across the polynomial boundary.
      do_reset();
      send_beats(64, 12'h924, 1'b1);
      begin
         int b;
         b = 0;
         while (n_last < 1 && b < 500) begin
            @(posedge clk); #1;
            b++;
         end
         check("drain_last_seen", n_last, 1);
      end
      check("drain_no_push", n_push, 64);
      check("drain_ready_back", {31'd0, ready_o}, 32'd1);
      @(posedge clk); #1;
      check("drain_next_push", n_push, 65);
      valid_i = 1'b0;

      // Reset mid-polynomial.
      do_reset();
      send_beats(30, 12'h688, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_valid_o", {31'd0, valid_o}, 32'd0);
      check("midrst_last_o",  {31'd0, last_o},  32'd0);
      check("midrst_data_o",  data_o,           32'd0);
      check("midrst_ready_o", {31'd0, ready_o}, 32'd1);
      model_clear();
      rst = 1'b0;
      send_beats(64, 12'h924, 1'b0);
      wait_pops(24);
      repeat (10) @(posedge clk);
      #1;
      check("midrst_pops",  n_pop,  24);
      check("midrst_lasts", n_last, 1);
      if (pop_log.size() >= 1) check("midrst_w0", pop_log[0], 32'h24924924);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
